// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner and the operand-entry decoder.
// FSM encodings, idle/reset patterns and the key code mapping.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_ACCEPT   = 2'd2,
        ST_HOLD     = 2'd3
    } kp_state_e;

    localparam logic [3:0] ROWS_IDLE = 4'hF;
    localparam logic [3:0] COL_RESET = 4'b1110;

    // Lowest-index active-low row; caller guarantees at least one is low.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] r;
        r = 2'd3;
        if (!rows[2]) r = 2'd2;
        if (!rows[1]) r = 2'd1;
        if (!rows[0]) r = 2'd0;
        return r;
    endfunction

    // Key code as seen by the operand-entry decoder.
    function automatic logic [3:0] key_map(input logic [1:0] row,
                                           input logic [1:0] col);
        return {row, col};
    endfunction

    // Active-low one-cold column drive, rotated from the reset pattern.
    function automatic logic [3:0] col_drive(input logic [1:0] col);
        logic [7:0] w;
        w = {COL_RESET, COL_RESET} << col;
        return w[7:4];
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous keypad rows.
// Resets to all ones so an idle (pulled-up) keypad is seen at reset.
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two-stage capture of the raw inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and a valid/ready key register.
// Column slots are paced by a clken-gated divider; one key code per press.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       clken,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_pressed,
    output logic       overflow
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       rows_s;
    logic [DIV_W-1:0] div_q, div_d;
    kp_state_e        state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             pressed_q, pressed_d;
    logic             ovf_q, ovf_d;
    logic             tick;
    logic             xfer;
    logic             idle;
    logic [CNT_W-1:0] cnt_inc;

    sync2 #(.W(4)) u_sync (
        .clk   (clkin),
        .rst_n (rst),
        .d     (row_in),
        .q     (rows_s)
    );

    assign tick    = clken && (div_q == DIV_MAX);
    assign xfer    = valid_q && key_ready;
    assign idle    = (rows_s == ROWS_IDLE);
    assign cnt_inc = cnt_q + CNT_ONE;

    // Column slot divider, frozen while clken is low.
    always_comb begin
        div_d = div_q;
        if (clken) div_d = tick ? '0 : div_q + 1'b1;
    end

    // Scan/debounce FSM next state plus key register updates.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        valid_d   = valid_q;
        pressed_d = pressed_q;
        ovf_d     = ovf_q;
        if (xfer) valid_d = 1'b0;
        unique case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (idle) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_d   = low_row(rows_s);
                        cnt_d   = CNT_ONE;
                        state_d = (CNT_ONE == CNT_MAX) ? ST_ACCEPT
                                                       : ST_DEBOUNCE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (!idle && low_row(rows_s) == row_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) state_d = ST_ACCEPT;
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_q + 2'd1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_ACCEPT: begin
                if (clken) begin
                    pressed_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_HOLD;
                    if (valid_q && !xfer) begin
                        ovf_d = 1'b1;
                    end else begin
                        code_d  = key_map(row_q, col_q);
                        valid_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    if (idle) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            pressed_d = 1'b0;
                            cnt_d     = '0;
                            col_d     = col_q + 2'd1;
                            state_d   = ST_SCAN;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            state_q   <= ST_SCAN;
            col_q     <= 2'd0;
            row_q     <= 2'd0;
            cnt_q     <= '0;
            code_q    <= 4'h0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
            ovf_q     <= ovf_d;
        end
    end

    assign col_out     = col_drive(col_q);
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_pressed = pressed_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// Timing offsets are relative to the edge where the target column appears.
module tb_keypad_scanner;

    logic       clkin = 1'b0;
    logic       rst = 1'b0;
    logic       clken = 1'b1;
    logic [3:0] row_in = 4'hF;
    logic       key_ready = 1'b0;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;
    logic       overflow;

    int n_chk = 0;
    int n_bad = 0;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clkin       (clkin),
        .rst         (rst),
        .clken       (clken),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_pressed (key_pressed),
        .overflow    (overflow)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clkin);
        @(negedge clkin);
        rst = 1'b1;
    endtask

    // Stops one step after the edge on which column c becomes driven.
    task automatic wait_col(input logic [3:0] c);
        for (int i = 0; i < 100 && col_out == c; i++) step(1);
        for (int i = 0; i < 100 && col_out != c; i++) step(1);
        chk("wait_col", col_out, c);
    endtask

    task automatic wait_kv(input logic v);
        for (int i = 0; i < 200 && key_valid != v; i++) step(1);
        chk("wait_kv", key_valid, v);
    endtask

    task automatic wait_kp(input logic v);
        for (int i = 0; i < 200 && key_pressed != v; i++) step(1);
        chk("wait_kp", key_pressed, v);
    endtask

    initial begin
        logic [3:0] exp_col;

        do_reset();
        #1;
        chk("rst_col", col_out, 4'b1110);
        chk("rst_kv", key_valid, 1'b0);
        chk("rst_kp", key_pressed, 1'b0);
        chk("rst_code", key_code, 4'h0);
        chk("rst_ovf", overflow, 1'b0);

        // idle scan: column advances on edges 4, 8, 12, ...
        for (int n = 1; n <= 40; n++) begin
            step(1);
            exp_col = ~(4'b0001 << ((n / 4) % 4));
            chk("idle_col", col_out, exp_col);
        end
        chk("idle_kv", key_valid, 1'b0);

        // press row2/col1 -> 9, valid one cycle after third tick
        wait_col(4'b1101);
        row_in = 4'b1011;
        step(12);
        chk("lat_kv0", key_valid, 1'b0);
        chk("lat_col", col_out, 4'b1101);
        step(1);
        chk("lat_kv1", key_valid, 1'b1);
        chk("lat_code", key_code, 4'h9);
        chk("lat_kp", key_pressed, 1'b1);
        key_ready = 1'b1;
        step(1);
        chk("xfer_kv", key_valid, 1'b0);
        key_ready = 1'b0;
        row_in = 4'hF;
        wait_kp(1'b0);

        // bounce: low for two ticks only
        wait_col(4'b1101);
        row_in = 4'b1110;
        step(4);
        chk("bnc_hold1", col_out, 4'b1101);
        step(4);
        row_in = 4'hF;
        step(3);
        chk("bnc_hold2", col_out, 4'b1101);
        step(1);
        chk("bnc_next", col_out, 4'b1011);
        chk("bnc_kv", key_valid, 1'b0);
        chk("bnc_kp", key_pressed, 1'b0);

        // overflow: second key while first unconsumed
        wait_col(4'b1101);
        row_in = 4'b1011;
        wait_kv(1'b1);
        row_in = 4'hF;
        wait_kp(1'b0);
        wait_col(4'b0111);
        row_in = 4'b1110;
        wait_kp(1'b1);
        chk("ovf_code", key_code, 4'h9);
        chk("ovf_kv", key_valid, 1'b1);
        chk("ovf_set", overflow, 1'b1);
        row_in = 4'hF;
        wait_kp(1'b0);
        chk("ovf_sticky", overflow, 1'b1);

        // accept coincident with transfer
        do_reset();
        #1;
        chk("rst2_ovf", overflow, 1'b0);
        wait_col(4'b1101);
        row_in = 4'b1011;
        wait_kv(1'b1);
        row_in = 4'hF;
        wait_kp(1'b0);
        wait_col(4'b0111);
        row_in = 4'b1110;
        step(12);
        chk("co_code0", key_code, 4'h9);
        key_ready = 1'b1;
        step(1);
        chk("co_code", key_code, 4'h3);
        chk("co_kv", key_valid, 1'b1);
        chk("co_ovf", overflow, 1'b0);
        step(1);
        chk("co_kv0", key_valid, 1'b0);
        key_ready = 1'b0;
        row_in = 4'hF;
        wait_kp(1'b0);

        // clken low for 20 cycles mid-debounce
        do_reset();
        wait_col(4'b1101);
        row_in = 4'b1011;
        step(5);
        clken = 1'b0;
        step(20);
        chk("cke_col", col_out, 4'b1101);
        chk("cke_kv", key_valid, 1'b0);
        clken = 1'b1;
        step(7);
        chk("cke_kv0", key_valid, 1'b0);
        step(1);
        chk("cke_kv1", key_valid, 1'b1);
        chk("cke_code", key_code, 4'h9);

        // async reset while holding
        step(2);
        chk("hold_kp", key_pressed, 1'b1);
        @(negedge clkin);
        rst = 1'b0;
        #1;
        chk("arst_col", col_out, 4'b1110);
        chk("arst_kv", key_valid, 1'b0);
        chk("arst_kp", key_pressed, 1'b0);
        chk("arst_code", key_code, 4'h0);
        chk("arst_ovf", overflow, 1'b0);
        row_in = 4'hF;
        do_reset();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
